// File: rtl/player_pkg.sv
// Shared player constants: direction codes, FSM states, screen geometry.
// Provides sel_dir(), the U>D>R>L priority pick from button levels.
package player_pkg;

  localparam logic [3:0] DIR_UP    = 4'd8;
  localparam logic [3:0] DIR_DOWN  = 4'd4;
  localparam logic [3:0] DIR_RIGHT = 4'd2;
  localparam logic [3:0] DIR_LEFT  = 4'd1;
  localparam logic [3:0] DIR_NONE  = 4'd0;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int STEP_PX  = 12;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    HOLD
  } state_t;

  function automatic logic [3:0] sel_dir(
    input logic [3:0] b
  );
    logic [3:0] d;
    d = DIR_NONE;
    if (b[3])      d = DIR_UP;
    else if (b[2]) d = DIR_DOWN;
    else if (b[1]) d = DIR_RIGHT;
    else if (b[0]) d = DIR_LEFT;
    return d;
  endfunction

endpackage

// File: rtl/player_move_scheduler_if.sv
// Buttons/enables in, req/ack step request out, plus status.
// master: scheduler side. slave: buttons + position logic side.
interface player_move_scheduler_if;

  logic [3:0]  btns;
  logic        upEnable;
  logic        downEnable;
  logic        rightEnable;
  logic        leftEnable;
  logic        moveReq;
  logic [3:0]  moveDir;
  logic        moveAck;
  logic        blocked;
  logic [15:0] stepCount;

  modport master (
    input  btns,
    input  upEnable,
    input  downEnable,
    input  rightEnable,
    input  leftEnable,
    input  moveAck,
    output moveReq,
    output moveDir,
    output blocked,
    output stepCount
  );

  modport slave (
    output btns,
    output upEnable,
    output downEnable,
    output rightEnable,
    output leftEnable,
    output moveAck,
    input  moveReq,
    input  moveDir,
    input  blocked,
    input  stepCount
  );

endinterface

// File: rtl/move_repeat_timer.sv
// Hold-delay / auto-repeat down-counter with expired and pending flags.
// Ports: clk, rst_n, i_load_delay, i_load_repeat, i_run, i_wait,
// o_expired, o_pending. Present only with PLAYER_MOVE_AUTOREPEAT_EN.
`ifdef PLAYER_MOVE_AUTOREPEAT_EN
module move_repeat_timer #(
  parameter int DELAY_TICKS  = 25_000_000,
  parameter int REPEAT_TICKS = 8_000_000,
  parameter int CNT_W        = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load_delay,
  input  logic i_load_repeat,
  input  logic i_run,
  input  logic i_wait,
  output logic o_expired,
  output logic o_pending
);

  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LD = CNT_W'(REPEAT_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;

  assign o_expired = (r_cnt == '0);
  assign o_pending = r_pend;

  // Counter parks at zero; an expiry seen while the request is still
  // outstanding is remembered so HOLD can launch right after the ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else if (i_load_delay) begin
      r_cnt  <= DLY_LD;
      r_pend <= 1'b0;
    end else if (i_load_repeat) begin
      r_cnt  <= REP_LD;
      r_pend <= 1'b0;
    end else if (i_run) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (i_wait && r_cnt == '0) r_pend <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/player_move_scheduler.sv
// Player move scheduler: priority pick, collision gate, req/ack steps.
// Ports: clk, rst_n (sync, active-low), mv (master modport).
// PLAYER_MOVE_AUTOREPEAT_EN adds hold-delay/auto-repeat stepping.
module player_move_scheduler
  import player_pkg::*;
#(
  parameter int DELAY_TICKS  = 25_000_000,
  parameter int REPEAT_TICKS = 8_000_000,
  parameter int CNT_W        = 25
) (
  input logic                    clk,
  input logic                    rst_n,
  player_move_scheduler_if.master mv
);

  if (DELAY_TICKS < 1 || REPEAT_TICKS < 1 ||
      CNT_W < 1 || CNT_W > 30 ||
      DELAY_TICKS > (1 << CNT_W) ||
      REPEAT_TICKS > (1 << CNT_W)) begin : g_bad_cfg
    $error("player_move_scheduler: bad timing parameters");
  end

  state_t      r_state;
  logic [3:0]  r_dir;
  logic        r_req;
  logic [3:0]  r_mdir;
  logic        r_blocked;
  logic [15:0] r_step_cnt;

  logic [3:0]  w_sel;
  logic        w_held;
  logic        w_en;
  logic        w_rep;

  assign w_sel  = sel_dir(mv.btns);
  assign w_held = |(mv.btns & r_dir);

  always_comb begin
    w_en = 1'b0;
    unique case (r_dir)
      DIR_UP:    w_en = mv.upEnable;
      DIR_DOWN:  w_en = mv.downEnable;
      DIR_RIGHT: w_en = mv.rightEnable;
      DIR_LEFT:  w_en = mv.leftEnable;
      default:   w_en = 1'b0;
    endcase
  end

`ifdef PLAYER_MOVE_AUTOREPEAT_EN
  logic w_ld_dly;
  logic w_ld_rep;
  logic w_run;
  logic w_wait;
  logic w_exp;
  logic w_pend;

  assign w_ld_dly = (r_state == IDLE && w_sel != DIR_NONE) ||
                    (r_state == HOLD && w_held && w_sel != r_dir);
  assign w_rep    = w_exp | w_pend;
  assign w_ld_rep = r_state == HOLD && w_held &&
                    w_sel == r_dir && w_rep;
  assign w_run    = (r_state != IDLE);
  assign w_wait   = (r_state == WAIT_ACK);

  move_repeat_timer #(
    .DELAY_TICKS (DELAY_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_delay (w_ld_dly),
    .i_load_repeat(w_ld_rep),
    .i_run        (w_run),
    .i_wait       (w_wait),
    .o_expired    (w_exp),
    .o_pending    (w_pend)
  );
`else
  assign w_rep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dir      <= DIR_NONE;
      r_req      <= 1'b0;
      r_mdir     <= DIR_NONE;
      r_blocked  <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_blocked <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_sel != DIR_NONE) begin
            r_dir   <= w_sel;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (w_en) begin
            r_req   <= 1'b1;
            r_mdir  <= r_dir;
            r_state <= WAIT_ACK;
          end else begin
            r_blocked <= 1'b1;
            r_state   <= HOLD;
          end
        end
        WAIT_ACK: begin
          if (mv.moveAck) begin
            r_req      <= 1'b0;
            r_mdir     <= DIR_NONE;
            r_step_cnt <= r_step_cnt + 16'd1;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          // Releasing the held direction ends the burst outright.
          if (!w_held) begin
            r_state <= IDLE;
          end else if (w_sel != r_dir) begin
            r_dir   <= w_sel;
            r_state <= LAUNCH;
          end else if (w_rep) begin
            r_state <= LAUNCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mv.moveReq   = r_req;
  assign mv.moveDir   = r_mdir;
  assign mv.blocked   = r_blocked;
  assign mv.stepCount = r_step_cnt;

endmodule
